// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C dummy target: byte width, idle-bus byte and byte type.
package i2c_target_pkg;

   localparam int unsigned I2C_DATA_W = 8;

   typedef logic [I2C_DATA_W-1:0] i2c_byte_t;

   localparam i2c_byte_t I2C_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_fifo_ptr.sv
// FIFO pointer register: index in the low bits plus one wrap bit on top.
module i2c_fifo_ptr #(
   parameter int unsigned PTR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // Clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/i2c_loopback_fifo.sv
// Byte FIFO behind the I2C target interface: stores controller writes, returns them on reads.
// Status and head byte are decoded from registered pointers/memory only.
module i2c_loopback_fifo
   import i2c_target_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic             FLUSH,
   input  logic             ACC_WR,
   input  logic [7:0]       ACC_WDATA,
   input  logic             ACC_RD,
   output logic [7:0]       ACC_RDATA,
   output logic             FIFO_EMPTY,
   output logic             FIFO_FULL,
   output logic [CNT_W-1:0] FIFO_COUNT,
   output logic             FIFO_OVF,
   output logic             FIFO_UDF
);

   localparam int unsigned IDX_W = CNT_W - 1;

   i2c_byte_t        mem [DEPTH];
   logic [CNT_W-1:0] wp;
   logic [CNT_W-1:0] rp;
   logic [IDX_W-1:0] wp_idx;
   logic [IDX_W-1:0] rp_idx;
   logic             pop_ok;
   logic             push_ok;
   logic             wr_en;
   logic             rd_en;

   assign wp_idx = wp[IDX_W-1:0];
   assign rp_idx = rp[IDX_W-1:0];

   assign FIFO_EMPTY = (wp == rp);
   assign FIFO_FULL  = (wp_idx == rp_idx) && (wp[IDX_W] != rp[IDX_W]);
   assign FIFO_COUNT = wp - rp;
   assign ACC_RDATA  = FIFO_EMPTY ? I2C_IDLE_BYTE : mem[rp_idx];

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign pop_ok  = ACC_RD && !FIFO_EMPTY;
   assign push_ok = ACC_WR && (!FIFO_FULL || pop_ok);
   assign wr_en   = push_ok && !FLUSH;
   assign rd_en   = pop_ok && !FLUSH;

   i2c_fifo_ptr #(.PTR_W(CNT_W)) u_wp (
      .clk   (CLK),
      .rst_n (RESET_n),
      .clr   (FLUSH),
      .inc   (wr_en),
      .ptr   (wp)
   );

   i2c_fifo_ptr #(.PTR_W(CNT_W)) u_rp (
      .clk   (CLK),
      .rst_n (RESET_n),
      .clr   (FLUSH),
      .inc   (rd_en),
      .ptr   (rp)
   );

   // Storage is intentionally not reset; the idle byte masks it while empty.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wp_idx] <= ACC_WDATA;
      end
   end

   // Sticky error flags, cleared only by flush or reset.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         FIFO_OVF <= 1'b0;
         FIFO_UDF <= 1'b0;
      end else if (FLUSH) begin
         FIFO_OVF <= 1'b0;
         FIFO_UDF <= 1'b0;
      end else begin
         if (ACC_WR && !push_ok) begin
            FIFO_OVF <= 1'b1;
         end
         if (ACC_RD && FIFO_EMPTY) begin
            FIFO_UDF <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_loopback_fifo.sv
// Bench for i2c_loopback_fifo: directed steps plus random traffic against a queue model.
module tb_i2c_loopback_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             CLK = 1'b0;
   logic             RESET_n;
   logic             FLUSH;
   logic             ACC_WR;
   logic [7:0]       ACC_WDATA;
   logic             ACC_RD;
   logic [7:0]       ACC_RDATA;
   logic             FIFO_EMPTY;
   logic             FIFO_FULL;
   logic [CNT_W-1:0] FIFO_COUNT;
   logic             FIFO_OVF;
   logic             FIFO_UDF;

   logic [7:0] q [$];
   bit         m_ovf;
   bit         m_udf;
   int         n_total;
   int         n_pass;

   always #10 CLK = ~CLK;

   i2c_loopback_fifo #(.DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RESET_n    (RESET_n),
      .FLUSH      (FLUSH),
      .ACC_WR     (ACC_WR),
      .ACC_WDATA  (ACC_WDATA),
      .ACC_RD     (ACC_RD),
      .ACC_RDATA  (ACC_RDATA),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_FULL  (FIFO_FULL),
      .FIFO_COUNT (FIFO_COUNT),
      .FIFO_OVF   (FIFO_OVF),
      .FIFO_UDF   (FIFO_UDF)
   );

   task automatic cmp(input string tag, input string field, input logic [7:0] got,
                      input logic [7:0] want);
      n_total++;
      assert (got === want) n_pass++;
      else $error("FAIL %s %s: observed %h expected %h", tag, field, got, want);
   endtask

   task automatic check(input string tag);
      logic [7:0] exp_rd;
      int         sz;
      sz     = q.size();
      exp_rd = (sz > 0) ? q[0] : 8'hFF;
      cmp(tag, "rdata", ACC_RDATA, exp_rd);
      cmp(tag, "empty", {7'd0, FIFO_EMPTY}, {7'd0, (sz == 0)});
      cmp(tag, "full",  {7'd0, FIFO_FULL},  {7'd0, (sz == DEPTH)});
      cmp(tag, "count", 8'(FIFO_COUNT), 8'(sz));
      cmp(tag, "ovf",   {7'd0, FIFO_OVF},   {7'd0, m_ovf});
      cmp(tag, "udf",   {7'd0, FIFO_UDF},   {7'd0, m_udf});
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Queue semantics: a pop frees room for a same-cycle push; empty pop is an underflow.
   task automatic model_step(input bit wr, input logic [7:0] d, input bit rd, input bit fl);
      bit do_pop;
      bit do_push;
      if (fl) begin
         model_reset();
      end else begin
         do_pop  = rd && (q.size() > 0);
         do_push = wr && ((q.size() < DEPTH) || do_pop);
         if (wr && !do_push) m_ovf = 1'b1;
         if (rd && q.size() == 0) m_udf = 1'b1;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
   endtask

   task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit fl,
                       input string tag, input bit chk);
      ACC_WR    = wr;
      ACC_WDATA = d;
      ACC_RD    = rd;
      FLUSH     = fl;
      @(posedge CLK);
      model_step(wr, d, rd, fl);
      #1;
      ACC_WR = 1'b0;
      ACC_RD = 1'b0;
      FLUSH  = 1'b0;
      if (chk) check(tag);
   endtask

   initial begin
      logic [7:0] v;
      bit         w;
      bit         r;
      bit         f;

      RESET_n   = 1'b1;
      FLUSH     = 1'b0;
      ACC_WR    = 1'b0;
      ACC_WDATA = 8'h00;
      ACC_RD    = 1'b0;
      n_total   = 0;
      n_pass    = 0;
      model_reset();
      #1 RESET_n = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK) RESET_n = 1'b1;
      @(posedge CLK);
      #1 check("reset");

      // Ordering
      step(1, 8'hAA, 0, 0, "ord_push", 1);
      step(1, 8'h55, 0, 0, "ord_push", 1);
      step(1, 8'h01, 0, 0, "ord_push", 1);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, "ord_pop", 1);

      // Fill past full
      for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, "fill", 1);
      for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "drain", 1);
      step(0, 8'h00, 0, 1, "flush1", 1);

      // Index wrap with concurrent traffic
      for (int i = 0; i < 12; i++) step(1, 8'(8'h40 + i), 0, 0, "wr12", 0);
      for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0, "rd12", 1);
      for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), (i % 2) == 1, 0, "wrap", 1);
      while (q.size() < DEPTH) step(1, 8'(8'hC0 + q.size()), 0, 0, "refill", 0);
      check("full_pre");
      for (int i = 0; i < 4; i++) step(1, 8'(8'hE0 + i), 1, 0, "full_rw", 1);
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, "wrap_drain", 1);

      // Underflow and empty push+pop
      step(0, 8'h00, 1, 0, "udf", 1);
      step(1, 8'h3C, 1, 0, "empty_rw", 1);

      // Flush beats a concurrent push
      step(0, 8'h00, 0, 1, "flush2", 1);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, "fill5", 0);
      while (q.size() < DEPTH) step(1, 8'h99, 0, 0, "fill16", 0);
      step(1, 8'h77, 0, 0, "ovf_set", 1);
      while (q.size() > 0) step(0, 8'h00, 1, 0, "drain2", 0);
      step(0, 8'h00, 1, 0, "udf_set", 1);
      step(1, 8'h5A, 0, 1, "flush_wr", 1);

      // Asynchronous reset between edges
      for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, "fill3", 1);
      #4 RESET_n = 1'b0;
      model_reset();
      #1 check("async_rst");
      @(posedge CLK);
      #1 check("rst_hold");
      @(negedge CLK) RESET_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         f = ($urandom_range(0, 99) < 2);
         v = 8'($urandom);
         step(w, v, r, f, "rand", 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
